// File: rtl/mini_cpu_step_ctrl.sv
// mini_cpu_step_ctrl: host-command sequencer that drives the mini_cpu step pin.
// It supports halt, free-run, step-N and clear-count commands, and keeps a
// saturating count of completed pulses.
// Define MINI_CPU_STEP_BP_EN to build the PC breakpoint comparator. Without it,
// bp_en, bp_pc and cpu_pc are ignored and the BP halt cause never occurs.
module mini_cpu_step_ctrl #(
    parameter int unsigned PC_W      = 4,
    parameter int unsigned CNT_W     = 16,
    parameter int unsigned STEP_HIGH = 1,
    parameter int unsigned STEP_LOW  = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             cmd_valid,
    input  logic [1:0]       cmd_op,
    input  logic [CNT_W-1:0] cmd_arg,
    input  logic             bp_en,
    input  logic [PC_W-1:0]  bp_pc,
    input  logic [PC_W-1:0]  cpu_pc,
    output logic             cpu_step,
    output logic             busy,
    output logic [1:0]       halt_cause,
    output logic             halt_pulse,
    output logic             cmd_err,
    output logic [CNT_W-1:0] step_count
);

    localparam int unsigned PH_MAX = (STEP_HIGH > STEP_LOW) ? STEP_HIGH : STEP_LOW;
    localparam int unsigned PH_W   = (PH_MAX > 1) ? $clog2(PH_MAX) : 1;

    localparam logic [1:0] OP_HALT = 2'b00;
    localparam logic [1:0] OP_RUN  = 2'b01;
    localparam logic [1:0] OP_STEP = 2'b10;
    localparam logic [1:0] OP_CLR  = 2'b11;

    localparam logic [1:0] CAUSE_NONE = 2'b00;
    localparam logic [1:0] CAUSE_DONE = 2'b01;
    localparam logic [1:0] CAUSE_HOST = 2'b10;
    localparam logic [1:0] CAUSE_BP   = 2'b11;

    localparam logic [PH_W-1:0] HI_LAST = PH_W'(STEP_HIGH - 1);
    localparam logic [PH_W-1:0] LO_LAST = PH_W'(STEP_LOW - 1);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_HI   = 2'd1,
        ST_LO   = 2'd2
    } state_t;

    state_t           state, state_d;
    logic [PH_W-1:0]  phase, phase_d;
    logic [CNT_W-1:0] remaining, remaining_d;
    logic             run_mode, run_mode_d;
    logic             halt_req, halt_req_d;
    logic [CNT_W-1:0] count_d;
    logic [1:0]       cause_d;
    logic             halt_pulse_d;
    logic             cmd_err_d;
    logic             bp_hit_c;

    // Breakpoint compare on the PC sampled in the last low cycle.
`ifdef MINI_CPU_STEP_BP_EN
    assign bp_hit_c = bp_en && (cpu_pc == bp_pc);
`else
    logic unused_bp;
    assign unused_bp = ^{bp_en, bp_pc, cpu_pc};
    assign bp_hit_c  = 1'b0;
`endif

    // State register and all registered outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= ST_IDLE;
            phase      <= '0;
            remaining  <= '0;
            run_mode   <= 1'b0;
            halt_req   <= 1'b0;
            cpu_step   <= 1'b0;
            busy       <= 1'b0;
            halt_cause <= CAUSE_NONE;
            halt_pulse <= 1'b0;
            cmd_err    <= 1'b0;
            step_count <= '0;
        end else begin
            state      <= state_d;
            phase      <= phase_d;
            remaining  <= remaining_d;
            run_mode   <= run_mode_d;
            halt_req   <= halt_req_d;
            cpu_step   <= (state_d == ST_HI);
            busy       <= (state_d != ST_IDLE);
            halt_cause <= cause_d;
            halt_pulse <= halt_pulse_d;
            cmd_err    <= cmd_err_d;
            step_count <= count_d;
        end
    end

    // Next-state, command decode, pulse completion and halt priority.
    always_comb begin
        state_d      = state;
        phase_d      = phase;
        remaining_d  = remaining;
        run_mode_d   = run_mode;
        halt_req_d   = halt_req;
        count_d      = step_count;
        cause_d      = halt_cause;
        halt_pulse_d = 1'b0;
        cmd_err_d    = 1'b0;

        // While a pulse train runs, HALT is latched and anything else is dropped.
        if ((state != ST_IDLE) && cmd_valid) begin
            if (cmd_op == OP_HALT) begin
                halt_req_d = 1'b1;
            end else begin
                cmd_err_d = 1'b1;
            end
        end

        case (state)
            ST_IDLE: begin
                if (cmd_valid) begin
                    case (cmd_op)
                        OP_RUN: begin
                            run_mode_d = 1'b1;
                            phase_d    = '0;
                            state_d    = ST_HI;
                        end
                        OP_STEP: begin
                            if (cmd_arg == '0) begin
                                halt_pulse_d = 1'b1;
                                cause_d      = CAUSE_DONE;
                            end else begin
                                remaining_d = cmd_arg;
                                run_mode_d  = 1'b0;
                                phase_d     = '0;
                                state_d     = ST_HI;
                            end
                        end
                        OP_CLR: begin
                            count_d = '0;
                        end
                        default: begin
                        end
                    endcase
                end
            end
            ST_HI: begin
                if (phase == HI_LAST) begin
                    phase_d = '0;
                    state_d = ST_LO;
                end else begin
                    phase_d = phase + PH_W'(1);
                end
            end
            ST_LO: begin
                if (phase == LO_LAST) begin
                    phase_d = '0;
                    state_d = ST_HI;
                    if (step_count != '1) begin
                        count_d = step_count + CNT_W'(1);
                    end
                    if (!run_mode) begin
                        remaining_d = remaining - CNT_W'(1);
                    end
                    if (halt_req_d) begin
                        cause_d = CAUSE_HOST;
                        state_d = ST_IDLE;
                    end else if (bp_hit_c) begin
                        cause_d = CAUSE_BP;
                        state_d = ST_IDLE;
                    end else if (!run_mode && (remaining == CNT_W'(1))) begin
                        cause_d = CAUSE_DONE;
                        state_d = ST_IDLE;
                    end
                    if (state_d == ST_IDLE) begin
                        halt_pulse_d = 1'b1;
                        halt_req_d   = 1'b0;
                    end
                end else begin
                    phase_d = phase + PH_W'(1);
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

endmodule
